// File: rtl/usb_rx_pkg.sv
// Shared state encoding and constants for the USB receive decoder.
package usb_rx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ACTIVE,
        EOP1,
        EOP2,
        ABORT
    } state_t;

    // Sync field as received, first bit on the wire in the LSB.
    localparam logic [7:0] SYNC_BYTE        = 8'h80;
    localparam logic [2:0] MAX_ONES         = 3'd6;
    localparam int         CLKS_PER_BIT_DEF = 8;
    localparam int         SAMPLE_PT_DEF    = 3;

endpackage

// File: rtl/usb_rx_decoder_if.sv
// Line-side inputs and decoded-bit strobes of the USB receive decoder.
interface usb_rx_decoder_if;
    logic d_plus;
    logic d_minus;
    logic d_orig;
    logic new_bit;
    logic eop;
    logic stuff_err;
    logic line_err;
    logic sync_ok;

    modport master (
        output d_plus, d_minus,
        input  d_orig, new_bit, eop, stuff_err, line_err, sync_ok
    );

    modport slave (
        input  d_plus, d_minus,
        output d_orig, new_bit, eop, stuff_err, line_err, sync_ok
    );
endinterface

// File: rtl/usb_rx_edge_timer.sv
// Line synchroniser, D+ edge detector and bit-timing counter.
// The counter restarts on every D+ edge so bit timing tracks the sender.
module usb_rx_edge_timer
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SAMPLE_PT    = SAMPLE_PT_DEF
) (
    input  logic clk,
    input  logic n_rst,
    input  logic i_d_plus,
    input  logic i_d_minus,
    input  logic i_run,
    output logic o_dp_s,
    output logic o_dm_s,
    output logic o_edge,
    output logic o_sample
);
    localparam int              CW         = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]   CNT_LAST   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]   CNT_SAMPLE = CW'(SAMPLE_PT);

    logic          r_dp_meta;
    logic          r_dm_meta;
    logic          r_dp_s;
    logic          r_dm_s;
    logic          r_dp_d;
    logic [CW-1:0] r_cnt;
    logic          w_edge;

    // Reset to J so an idle bus produces no spurious edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_dp_meta <= 1'b1;
            r_dm_meta <= 1'b0;
            r_dp_s    <= 1'b1;
            r_dm_s    <= 1'b0;
            r_dp_d    <= 1'b1;
        end else begin
            r_dp_meta <= i_d_plus;
            r_dm_meta <= i_d_minus;
            r_dp_s    <= r_dp_meta;
            r_dm_s    <= r_dm_meta;
            r_dp_d    <= r_dp_s;
        end
    end

    assign w_edge = r_dp_s ^ r_dp_d;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_cnt <= '0;
        end else if (!i_run || w_edge || (r_cnt == CNT_LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign o_dp_s   = r_dp_s;
    assign o_dm_s   = r_dm_s;
    assign o_edge   = w_edge;
    assign o_sample = i_run && !w_edge && (r_cnt == CNT_SAMPLE);

endmodule

// File: rtl/usb_rx_decoder.sv
// USB receive decoder: NRZI decode, bit-unstuffing and EOP detection.
// Define USB_RX_SYNC_STRIP_EN to consume and check the sync field internally.
//
// state  | meaning
// IDLE   | bus idle, waiting for the first J->K transition
// ACTIVE | decoding payload bits
// EOP1   | first SE0 bit seen
// EOP2   | second SE0 bit seen, waiting for J
// ABORT  | packet abandoned, waiting for SE0
module usb_rx_decoder
    import usb_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
    parameter int SAMPLE_PT    = SAMPLE_PT_DEF
) (
    input logic             clk,
    input logic             n_rst,
    usb_rx_decoder_if.slave bus
);
    state_t     r_state;
    state_t     w_state_dec;
    state_t     w_state_nx;
    logic [2:0] r_ones;
    logic [2:0] w_ones_nx;
    logic       r_last_dp;
    logic       w_last_dp_nx;
    logic       r_d_orig;
    logic       r_new_bit;
    logic       r_eop;
    logic       r_stuff_err;
    logic       r_line_err;
    logic       r_sync_ok;
    logic       w_dp_s;
    logic       w_dm_s;
    logic       w_edge;
    logic       w_sample;
    logic       w_se0;
    logic       w_dec;
    logic       w_emit;
    logic       w_eop_nx;
    logic       w_stuff_nx;
    logic       w_line_dec;
    logic       w_sync_hold;
    logic       w_sync_done;
    logic       w_sync_match;
    logic       w_out_bit;

    usb_rx_edge_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .SAMPLE_PT    (SAMPLE_PT)
    ) u_edge_timer (
        .clk       (clk),
        .n_rst     (n_rst),
        .i_d_plus  (bus.d_plus),
        .i_d_minus (bus.d_minus),
        .i_run     (r_state != IDLE),
        .o_dp_s    (w_dp_s),
        .o_dm_s    (w_dm_s),
        .o_edge    (w_edge),
        .o_sample  (w_sample)
    );

    assign w_se0 = !w_dp_s && !w_dm_s;
    assign w_dec = (w_dp_s == r_last_dp);

    always_comb begin
        w_state_dec  = r_state;
        w_ones_nx    = r_ones;
        w_last_dp_nx = r_last_dp;
        w_emit       = 1'b0;
        w_eop_nx     = 1'b0;
        w_stuff_nx   = 1'b0;
        w_line_dec   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ones_nx = '0;
                if (w_edge && !w_dp_s && w_dm_s) begin
                    w_state_dec  = ACTIVE;
                    w_last_dp_nx = 1'b1;
                end
            end
            ACTIVE: begin
                if (w_sample) begin
                    if (w_se0) begin
                        w_state_dec = EOP1;
                    end else begin
                        w_last_dp_nx = w_dp_s;
                        if (!w_dec) begin
                            // A 0 after six 1s is a stuffed bit and is dropped.
                            w_ones_nx = '0;
                            w_emit    = (r_ones != MAX_ONES);
                        end else if (r_ones == MAX_ONES) begin
                            w_stuff_nx  = 1'b1;
                            w_state_dec = ABORT;
                        end else begin
                            w_ones_nx = r_ones + 3'd1;
                            w_emit    = 1'b1;
                        end
                    end
                end
            end
            EOP1: begin
                if (w_sample) begin
                    if (w_se0) begin
                        w_state_dec = EOP2;
                    end else begin
                        w_line_dec  = 1'b1;
                        w_state_dec = IDLE;
                    end
                end
            end
            EOP2: begin
                if (w_sample && !w_se0) begin
                    w_eop_nx    = w_dp_s;
                    w_line_dec  = !w_dp_s;
                    w_state_dec = IDLE;
                end
            end
            ABORT: begin
                if (w_sample && w_se0) begin
                    w_state_dec = EOP1;
                end
            end
            default: w_state_dec = IDLE;
        endcase
    end

`ifdef USB_RX_SYNC_STRIP_EN
    logic [3:0] r_sync_cnt;
    logic [7:0] r_sync_sh;
    logic [7:0] w_sync_word;

    assign w_sync_word  = {w_dec, r_sync_sh[7:1]};
    assign w_sync_hold  = w_emit && (r_sync_cnt != 4'd8);
    assign w_sync_done  = w_sync_hold && (r_sync_cnt == 4'd7);
    assign w_sync_match = (w_sync_word == SYNC_BYTE);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_sync_cnt <= '0;
            r_sync_sh  <= '0;
        end else if (r_state == IDLE) begin
            r_sync_cnt <= '0;
            r_sync_sh  <= '0;
        end else if (w_sync_hold) begin
            r_sync_cnt <= r_sync_cnt + 4'd1;
            r_sync_sh  <= w_sync_word;
        end
    end
`else
    assign w_sync_hold  = 1'b0;
    assign w_sync_done  = 1'b0;
    assign w_sync_match = 1'b0;
`endif

    assign w_state_nx = (w_sync_done && !w_sync_match) ? ABORT : w_state_dec;
    assign w_out_bit  = w_emit && !w_sync_hold;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_ones      <= '0;
            r_last_dp   <= 1'b1;
            r_d_orig    <= 1'b1;
            r_new_bit   <= 1'b0;
            r_eop       <= 1'b0;
            r_stuff_err <= 1'b0;
            r_line_err  <= 1'b0;
            r_sync_ok   <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_ones      <= w_ones_nx;
            r_last_dp   <= w_last_dp_nx;
            r_d_orig    <= w_out_bit ? w_dec : r_d_orig;
            r_new_bit   <= w_out_bit;
            r_eop       <= w_eop_nx;
            r_stuff_err <= w_stuff_nx;
            r_line_err  <= w_line_dec || (w_sync_done && !w_sync_match);
            r_sync_ok   <= w_sync_done && w_sync_match;
        end
    end

    assign bus.d_orig    = r_d_orig;
    assign bus.new_bit   = r_new_bit;
    assign bus.eop       = r_eop;
    assign bus.stuff_err = r_stuff_err;
    assign bus.line_err  = r_line_err;
    assign bus.sync_ok   = r_sync_ok;

endmodule

// File: tb/tb_usb_rx_decoder.sv
// Directed bench for usb_rx_decoder: line-symbol vectors with hand-decoded expectations.
// Symbols: J = idle level, K = opposite level, 0 = SE0; each symbol is one bit time.
module tb_usb_rx_decoder;
    import usb_rx_pkg::*;

`ifdef USB_RX_SYNC_STRIP_EN
    localparam bit STRIP = 1'b1;
`else
    localparam bit STRIP = 1'b0;
`endif
    localparam int BIT_CLKS = 8;

    logic clk = 1'b0;
    logic n_rst;

    usb_rx_decoder_if bus ();

    usb_rx_decoder #(
        .CLKS_PER_BIT (BIT_CLKS),
        .SAMPLE_PT    (3)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int    tests = 0;
    int    fails = 0;
    string got_bits = "";
    int    n_eop = 0, n_stuff = 0, n_line = 0, n_sync = 0;
    int    b_bits, b_eop, b_stuff, b_line, b_sync;

    always @(negedge clk) begin
        if (bus.new_bit) begin
            if (bus.d_orig) got_bits = {got_bits, "1"};
            else            got_bits = {got_bits, "0"};
        end
        if (bus.eop)       n_eop++;
        if (bus.stuff_err) n_stuff++;
        if (bus.line_err)  n_line++;
        if (bus.sync_ok)   n_sync++;
    end

    typedef struct {
        string name;
        string seq;
        string bits;
        int    eop;
        int    stuff;
        int    line;
    } vec_t;

    vec_t vecs[6];

    task automatic check_int(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_str(input string name, input string got, input string exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got '%s', expected '%s'", name, got, exp);
        end
    endtask

    task automatic hold(input byte c, input int n);
        case (c)
            "J":     begin bus.d_plus = 1'b1; bus.d_minus = 1'b0; end
            "K":     begin bus.d_plus = 1'b0; bus.d_minus = 1'b1; end
            default: begin bus.d_plus = 1'b0; bus.d_minus = 1'b0; end
        endcase
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_seq(input string s);
        for (int i = 0; i < s.len(); i++) hold(s[i], BIT_CLKS);
    endtask

    task automatic mark();
        b_bits  = got_bits.len();
        b_eop   = n_eop;
        b_stuff = n_stuff;
        b_line  = n_line;
        b_sync  = n_sync;
    endtask

    // Every packet starts with the 8-bit sync field; with stripping it is
    // consumed, reported once on sync_ok and removed from the bit stream.
    task automatic expect_pkt(input string name, input string exp_bits,
                              input int e_eop, input int e_stuff, input int e_line);
        string eb;
        string gb;
        int    e_sync;
        eb     = exp_bits;
        e_sync = 0;
        if (STRIP) begin
            eb     = exp_bits.substr(8, exp_bits.len() - 1);
            e_sync = 1;
        end
        gb = got_bits.substr(b_bits, got_bits.len() - 1);
        check_str({name, ".bits"},  gb, eb);
        check_int({name, ".eop"},   n_eop - b_eop, e_eop);
        check_int({name, ".stuff"}, n_stuff - b_stuff, e_stuff);
        check_int({name, ".line"},  n_line - b_line, e_line);
        check_int({name, ".sync"},  n_sync - b_sync, e_sync);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"basic",    "KJKJKJKKJJKK00J",    "000000010101",   1, 0, 0};
        vecs[1] = '{"unstuff",  "KJKJKJKKKKKKKJJ00J", "00000001111111", 1, 0, 0};
        vecs[2] = '{"stufferr", "KJKJKJKKKKKKKKKK00J","0000000111111",  1, 1, 0};
        vecs[3] = '{"se0_1bit", "KJKJKJKKJK0K",       "0000000100",     0, 0, 1};
        vecs[4] = '{"se0_3bit", "KJKJKJKKJ000J",      "000000010",      1, 0, 0};
        vecs[5] = '{"eop2_k",   "KJKJKJKK00K",        "00000001",       0, 0, 1};

        n_rst       = 1'b0;
        bus.d_plus  = 1'b1;
        bus.d_minus = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_int("rst.strobes", int'({bus.new_bit, bus.eop, bus.stuff_err, bus.line_err, bus.sync_ok}), 0);
        check_int("rst.d_orig", int'(bus.d_orig), 1);
        check_int("rst.state", int'(dut.r_state), int'(IDLE));
        n_rst = 1'b1;
        hold("J", 16);

        for (int v = 0; v < 6; v++) begin
            hold("J", BIT_CLKS);
            mark();
            run_seq(vecs[v].seq);
            hold("J", 24);
            expect_pkt(vecs[v].name, vecs[v].bits, vecs[v].eop, vecs[v].stuff, vecs[v].line);
        end

        // Edge arrives on the sample count: the resync wins, one bit per symbol.
        hold("J", BIT_CLKS);
        mark();
        run_seq("KJKJKJKKJ");
        hold("J", 4);
        hold("K", BIT_CLKS);
        run_seq("00J");
        hold("J", 24);
        expect_pkt("edge_on_sample", "0000000100", 1, 0, 0);

        // Edge arrives one clock before the sample count.
        hold("J", BIT_CLKS);
        mark();
        run_seq("KJKJKJKKJ");
        hold("J", 3);
        hold("K", BIT_CLKS);
        run_seq("00J");
        hold("J", 24);
        expect_pkt("edge_early", "0000000100", 1, 0, 0);

        // Reset in the middle of a packet.
        hold("J", BIT_CLKS);
        run_seq("KJ");
        hold("K", 3);
        #2;
        n_rst = 1'b0;
        #1;
        mark();
        check_int("midrst.strobes", int'({bus.new_bit, bus.eop, bus.stuff_err, bus.line_err, bus.sync_ok}), 0);
        check_int("midrst.d_orig", int'(bus.d_orig), 1);
        check_int("midrst.state", int'(dut.r_state), int'(IDLE));
        hold("J", 2);
        n_rst = 1'b1;
        hold("J", 32);
        check_str("midrst.quiet_bits", got_bits.substr(b_bits, got_bits.len() - 1), "");
        check_int("midrst.quiet_strobes",
                  (n_eop - b_eop) + (n_stuff - b_stuff) + (n_line - b_line) + (n_sync - b_sync), 0);

        // Decoder must be fully usable again after the mid-packet reset.
        mark();
        run_seq(vecs[0].seq);
        hold("J", 24);
        expect_pkt("after_rst", vecs[0].bits, 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
